// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staged reset release controller.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    PERIPH    = 3'd2,
    CALIB     = 3'd3,
    CPU_GAP   = 3'd4,
    RUN       = 3'd5
  } state_t;

  localparam int RESTART_CNT_W = 8;

  // One extra bit over the largest count keeps the terminal compare free of wrap.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Loadable/clearable up-counter with a terminal-count compare; the
// sequencer shares one instance across hold, stage-gap and timeout counts.
module reset_seq_timer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/reset_seq.sv
// Staged reset release: hold, wait for PLL lock, then release periph, mem, cpu.
// Optional restart event counter built when RESET_SEQ_RESTART_CNT_EN is defined.
//
//   state     | meaning
//   ----------+----------------------------------------------
//   HOLD      | all resets asserted, minimum hold time running
//   WAIT_LOCK | hold done, waiting for pll_locked
//   PERIPH    | peripheral reset released, stage gap running
//   CALIB     | memory reset released, waiting for calib_done
//   CPU_GAP   | calibration done, gap before CPU release
//   RUN       | all resets released
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES   = 16,
  parameter int STAGE_GAP     = 8,
  parameter int CALIB_TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     pll_locked,
  input  logic                     calib_done,
  input  logic                     soft_rst_req,
  output logic                     rst_periph_o,
  output logic                     rst_mem_o,
  output logic                     rst_cpu_o,
  output logic [2:0]               state_o,
  output logic                     calib_timeout_o,
  output logic [RESTART_CNT_W-1:0] restart_cnt_o
);

  localparam int CW = cnt_width(HOLD_CYCLES, STAGE_GAP, CALIB_TIMEOUT);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] tc_val;
  logic          tc;
  logic          cnt_clr;
  logic          cnt_en;
  logic          timeout_hit;

  always_comb begin
    tc_val = '0;
    case (state_q)
      HOLD:             tc_val = CW'(HOLD_CYCLES - 1);
      PERIPH, CPU_GAP:  tc_val = CW'(STAGE_GAP - 1);
      CALIB:            tc_val = CW'(CALIB_TIMEOUT - 1);
      default:          tc_val = '0;
    endcase
  end

  always_comb begin
    state_d     = HOLD;
    timeout_hit = 1'b0;
    case (state_q)
      HOLD:      state_d = (tc && !soft_rst_req) ? WAIT_LOCK : HOLD;
      WAIT_LOCK: state_d = pll_locked ? PERIPH : WAIT_LOCK;
      PERIPH:    state_d = tc ? CALIB : PERIPH;
      CALIB: begin
        if (calib_done) begin
          state_d = CPU_GAP;
        end else if (tc) begin
          state_d     = HOLD;
          timeout_hit = 1'b1;
        end else begin
          state_d = CALIB;
        end
      end
      CPU_GAP:   state_d = tc ? RUN : CPU_GAP;
      RUN:       state_d = RUN;
      default:   state_d = HOLD;
    endcase

    // Aborts override the normal transitions; lock loss ranks above soft request.
    if (state_q != HOLD && soft_rst_req) begin
      state_d     = HOLD;
      timeout_hit = 1'b0;
    end
    if ((state_q inside {PERIPH, CALIB, CPU_GAP, RUN}) && !pll_locked) begin
      state_d     = HOLD;
      timeout_hit = 1'b0;
    end
  end

  // A soft request while already holding restarts the hold time.
  assign cnt_clr = (state_d != state_q) || (state_q == HOLD && soft_rst_req);
  assign cnt_en  = (state_q inside {HOLD, PERIPH, CALIB, CPU_GAP});

  reset_seq_timer #(
    .W (CW)
  ) u_timer (
    .clk      (clk),
    .rst_i    (rst_i),
    .clr      (cnt_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (cnt_en),
    .tc_val   (tc_val),
    .cnt      (cnt),
    .tc       (tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state_q         <= HOLD;
      rst_periph_o    <= 1'b0;
      rst_mem_o       <= 1'b0;
      rst_cpu_o       <= 1'b0;
      calib_timeout_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_periph_o <= (state_d inside {PERIPH, CALIB, CPU_GAP, RUN});
      rst_mem_o    <= (state_d inside {CALIB, CPU_GAP, RUN});
      rst_cpu_o    <= (state_d == RUN);
      if (timeout_hit) begin
        calib_timeout_o <= 1'b1;
      end
    end
  end

  assign state_o = state_q;

`ifdef RESET_SEQ_RESTART_CNT_EN
  logic                     restart_evt;
  logic [RESTART_CNT_W-1:0] restart_cnt_q;

  // Any entry to HOLD from a live state is an abort or a calibration timeout.
  assign restart_evt = (state_q inside {WAIT_LOCK, PERIPH, CALIB, CPU_GAP, RUN}) &&
                       (state_d == HOLD);

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      restart_cnt_q <= '0;
    end else if (restart_evt && (restart_cnt_q != '1)) begin
      restart_cnt_q <= restart_cnt_q + 1'b1;
    end
  end

  assign restart_cnt_o = restart_cnt_q;
`else
  assign restart_cnt_o = '0;
`endif

endmodule

// File: tb/tb_reset_seq.sv
// Scenario bench for reset_seq with a stage/elapsed-time reference model.
module tb_reset_seq;

  localparam int HOLD_CYCLES   = 16;
  localparam int STAGE_GAP     = 8;
  localparam int CALIB_TIMEOUT = 4096;
`ifdef RESET_SEQ_RESTART_CNT_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       pll_locked = 1'b0;
  logic       calib_done = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       rst_periph_o;
  logic       rst_mem_o;
  logic       rst_cpu_o;
  logic [2:0] state_o;
  logic       calib_timeout_o;
  logic [7:0] restart_cnt_o;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: stage number (spec encoding) and edges spent in it.
  int m_stage = 0;
  int m_el    = 0;
  int m_tmo   = 0;
  int m_rc    = 0;

  reset_seq #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .STAGE_GAP     (STAGE_GAP),
    .CALIB_TIMEOUT (CALIB_TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst_i           (rst_i),
    .pll_locked      (pll_locked),
    .calib_done      (calib_done),
    .soft_rst_req    (soft_rst_req),
    .rst_periph_o    (rst_periph_o),
    .rst_mem_o       (rst_mem_o),
    .rst_cpu_o       (rst_cpu_o),
    .state_o         (state_o),
    .calib_timeout_o (calib_timeout_o),
    .restart_cnt_o   (restart_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_step(input logic r, input logic l, input logic c, input logic s);
    bit abort;
    if (!r) begin
      m_stage = 0; m_el = 0; m_tmo = 0; m_rc = 0;
      return;
    end
    abort = (m_stage >= 2 && !l) || (m_stage != 0 && s);
    if (abort) begin
      m_stage = 0; m_el = 0;
      if (m_rc < 255) m_rc++;
      return;
    end
    if (m_stage == 0) begin
      if (s) m_el = 0;
      else if (m_el == HOLD_CYCLES - 1) begin m_stage = 1; m_el = 0; end
      else m_el++;
    end else if (m_stage == 1) begin
      if (l) begin m_stage = 2; m_el = 0; end
    end else if (m_stage == 2 || m_stage == 4) begin
      if (m_el == STAGE_GAP - 1) begin m_stage++; m_el = 0; end
      else m_el++;
    end else if (m_stage == 3) begin
      if (c) begin m_stage = 4; m_el = 0; end
      else if (m_el == CALIB_TIMEOUT - 1) begin
        m_stage = 0; m_el = 0; m_tmo = 1;
        if (m_rc < 255) m_rc++;
      end else m_el++;
    end
  endtask

  task automatic tick(input logic r, input logic l, input logic c, input logic s);
    @(negedge clk);
    rst_i = r; pll_locked = l; calib_done = c; soft_rst_req = s;
    @(posedge clk);
    model_step(r, l, c, s);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({rst_periph_o, rst_mem_o, rst_cpu_o, state_o, calib_timeout_o, restart_cnt_o} !== 15'd0)
      $display("FAIL reset_values: got p%b m%b c%b st%0d tmo%b rc%0d want all 0",
               rst_periph_o, rst_mem_o, rst_cpu_o, state_o, calib_timeout_o, restart_cnt_o);
    else n_pass++;
  endtask

  task automatic test_release_timing();
    int fp, fm, fc;
    fp = -1; fm = -1; fc = -1;
    do_reset();
    for (int k = 0; k < 45; k++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0);
      if (rst_periph_o && fp < 0) fp = k;
      if (rst_mem_o && fm < 0) fm = k;
      if (rst_cpu_o && fc < 0) fc = k;
    end
    n_total++;
    if (fp !== HOLD_CYCLES) $display("FAIL periph_release_edge: got E%0d want E%0d", fp, HOLD_CYCLES);
    else n_pass++;
    n_total++;
    if (fm !== HOLD_CYCLES + STAGE_GAP)
      $display("FAIL mem_release_edge: got E%0d want E%0d", fm, HOLD_CYCLES + STAGE_GAP);
    else n_pass++;
    n_total++;
    if (fc !== HOLD_CYCLES + 2 * STAGE_GAP + 1)
      $display("FAIL cpu_release_edge: got E%0d want E%0d", fc, HOLD_CYCLES + 2 * STAGE_GAP + 1);
    else n_pass++;
    n_total++;
    if (state_o !== 3'd5) $display("FAIL run_state: got %0d want 5", state_o);
    else n_pass++;
  endtask

  task automatic test_soft_hold();
    do_reset();
    for (int k = 0; k < 10; k++) tick(1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < HOLD_CYCLES - 1; k++) tick(1'b1, 1'b1, 1'b1, 1'b0);
    n_total++;
    if (state_o !== 3'd0) $display("FAIL soft_hold_extended: got state %0d want 0", state_o);
    else n_pass++;
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    n_total++;
    if (state_o !== 3'd1) $display("FAIL soft_hold_expiry: got state %0d want 1", state_o);
    else n_pass++;
  endtask

  task automatic test_lock_wait();
    do_reset();
    for (int k = 0; k < HOLD_CYCLES + 40; k++) tick(1'b1, 1'b0, 1'b1, 1'b0);
    n_total++;
    if ({state_o, rst_periph_o, rst_mem_o, rst_cpu_o} !== {3'd1, 3'b000})
      $display("FAIL lock_wait: got st%0d p%b m%b c%b want st1 p0 m0 c0",
               state_o, rst_periph_o, rst_mem_o, rst_cpu_o);
    else n_pass++;
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    n_total++;
    if ({state_o, rst_periph_o} !== {3'd2, 1'b1})
      $display("FAIL lock_rise: got st%0d p%b want st2 p1", state_o, rst_periph_o);
    else n_pass++;
  endtask

  task automatic test_soft_vs_calib();
    bit reached;
    reached = 1'b0;
    do_reset();
    for (int k = 0; k < 200 && !reached; k++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      if (state_o == 3'd3) reached = 1'b1;
    end
    n_total++;
    if (!reached) $display("FAIL reach_calib: got state %0d want 3", state_o);
    else n_pass++;
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    n_total++;
    if ({state_o, rst_periph_o, rst_mem_o, restart_cnt_o} !== {3'd0, 2'b00, 8'(RC_EN ? 1 : 0)})
      $display("FAIL soft_beats_calib: got st%0d p%b m%b rc%0d want st0 p0 m0 rc%0d",
               state_o, rst_periph_o, rst_mem_o, restart_cnt_o, RC_EN ? 1 : 0);
    else n_pass++;
  endtask

  task automatic test_calib_timeout();
    bit reached;
    int n;
    reached = 1'b0;
    n = 0;
    do_reset();
    for (int k = 0; k < 200 && !reached; k++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      if (state_o == 3'd3) reached = 1'b1;
    end
    for (int k = 0; k < CALIB_TIMEOUT + 100 && reached; k++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      n++;
      if (state_o != 3'd3) break;
    end
    n_total++;
    if (n !== CALIB_TIMEOUT) $display("FAIL calib_timeout_len: got %0d cycles want %0d", n, CALIB_TIMEOUT);
    else n_pass++;
    n_total++;
    if ({state_o, rst_periph_o, rst_mem_o, calib_timeout_o, restart_cnt_o} !==
        {3'd0, 2'b00, 1'b1, 8'(RC_EN ? 1 : 0)})
      $display("FAIL calib_timeout_state: got st%0d p%b m%b tmo%b rc%0d want st0 p0 m0 tmo1 rc%0d",
               state_o, rst_periph_o, rst_mem_o, calib_timeout_o, restart_cnt_o, RC_EN ? 1 : 0);
    else n_pass++;
    for (int k = 0; k < HOLD_CYCLES; k++) tick(1'b1, 1'b1, 1'b1, 1'b0);
    n_total++;
    if ({state_o, calib_timeout_o} !== {3'd1, 1'b1})
      $display("FAIL timeout_resequence: got st%0d tmo%b want st1 tmo1", state_o, calib_timeout_o);
    else n_pass++;
  endtask

  task automatic test_lock_loss_run();
    for (int k = 0; k < 40; k++) tick(1'b1, 1'b1, 1'b1, 1'b0);
    n_total++;
    if ({state_o, rst_cpu_o} !== {3'd5, 1'b1})
      $display("FAIL pre_lock_loss_run: got st%0d c%b want st5 c1", state_o, rst_cpu_o);
    else n_pass++;
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    n_total++;
    if ({state_o, rst_periph_o, rst_mem_o, rst_cpu_o, restart_cnt_o} !==
        {3'd0, 3'b000, 8'(RC_EN ? 2 : 0)})
      $display("FAIL lock_loss_abort: got st%0d p%b m%b c%b rc%0d want st0 p0 m0 c0 rc%0d",
               state_o, rst_periph_o, rst_mem_o, rst_cpu_o, restart_cnt_o, RC_EN ? 2 : 0);
    else n_pass++;
    for (int k = 0; k < 40; k++) tick(1'b1, 1'b1, 1'b1, 1'b0);
    n_total++;
    if ({state_o, rst_cpu_o} !== {3'd5, 1'b1})
      $display("FAIL lock_loss_resequence: got st%0d c%b want st5 c1", state_o, rst_cpu_o);
    else n_pass++;
  endtask

  task automatic test_rst_in_run();
    n_total++;
    if (calib_timeout_o !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", calib_timeout_o);
    else n_pass++;
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    n_total++;
    if ({state_o, rst_periph_o, rst_mem_o, rst_cpu_o, calib_timeout_o, restart_cnt_o} !== 15'd0)
      $display("FAIL rst_in_run: got st%0d p%b m%b c%b tmo%b rc%0d want all 0",
               state_o, rst_periph_o, rst_mem_o, rst_cpu_o, calib_timeout_o, restart_cnt_o);
    else n_pass++;
  endtask

  task automatic test_random();
    logic r, l, c, s;
    logic [14:0] got, exp;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 499) != 0);
      l = ($urandom_range(0, 99) >= 3);
      c = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 99) == 0);
      tick(r, l, c, s);
      got = {rst_periph_o, rst_mem_o, rst_cpu_o, state_o, calib_timeout_o, restart_cnt_o};
      exp = {1'(m_stage >= 2), 1'(m_stage >= 3), 1'(m_stage == 5), 3'(m_stage),
             1'(m_tmo), 8'(RC_EN ? m_rc : 0)};
      n_total++;
      if (got !== exp) $display("FAIL random_cycle_%0d: got %h want %h", k, got, exp);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_release_timing();
    test_soft_hold();
    test_lock_wait();
    test_soft_vs_calib();
    test_calib_timeout();
    test_lock_loss_run();
    test_rst_in_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reset_seq.md
Name: reset_seq

Overview:
- Staged reset release controller; sits directly downstream of the reset synchroniser and consumes its synchronised, active-low reset output.
- Holds all subsystem resets asserted for a minimum time, then waits for PLL lock.
- Releases peripheral, memory-controller and CPU resets in order, gating the CPU on memory calibration.
- Re-sequences on lock loss, software request or calibration timeout.

Parameters:
- HOLD_CYCLES, 16: minimum cycles in HOLD after reset deasserts (≥1).
- STAGE_GAP, 8: cycles between successive stage releases (≥1).
- CALIB_TIMEOUT, 4096: cycles allowed in CALIB for calib_done (≥2).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  synchronous active-low reset, driven by the reset synchroniser output.
- pll_locked  in  1  PLL lock, already synchronous to clk.
- calib_done  in  1  memory controller calibration complete, synchronous to clk.
- soft_rst_req  in  1  single-cycle software re-sequence request.
- rst_periph_o  out  1  active-low peripheral reset.
- rst_mem_o  out  1  active-low memory-controller reset.
- rst_cpu_o  out  1  active-low CPU reset.
- state_o  out  3  current FSM state encoding.
- calib_timeout_o  out  1  sticky flag: a calibration timeout occurred.
- restart_cnt_o  out  8  restart event count (optional feature).

Behaviour:
- Interface: one clock, clk. Reset rst_i is synchronous and active-low: rst_i=0 at an edge forces every register to its reset value at that edge, regardless of state.
- Reset values:
  - state=HOLD, counter=0.
  - rst_periph_o, rst_mem_o, rst_cpu_o = 0.
  - calib_timeout_o=0, restart_cnt_o=0.
- States and encodings: HOLD=0, WAIT_LOCK=1, PERIPH=2, CALIB=3, CPU_GAP=4, RUN=5. Codes 6 and 7 go to HOLD.
- Outputs are registered and update on the same edge as the state:
  - rst_periph_o=1 in PERIPH, CALIB, CPU_GAP, RUN.
  - rst_mem_o=1 in CALIB, CPU_GAP, RUN.
  - rst_cpu_o=1 in RUN only.
- One shared counter, cleared on every state change.
- HOLD: if cnt==HOLD_CYCLES-1, go to WAIT_LOCK; else cnt++. soft_rst_req in HOLD clears cnt, which extends the hold.
- WAIT_LOCK: pll_locked=1 → PERIPH; otherwise stay (no timeout).
- PERIPH: cnt==STAGE_GAP-1 → CALIB.
- CALIB:
  - calib_done=1 → CPU_GAP.
  - Else if cnt==CALIB_TIMEOUT-1 → HOLD and set calib_timeout_o (sticky until rst_i=0).
  - calib_done wins if both conditions hold in the same cycle.
- CPU_GAP: cnt==STAGE_GAP-1 → RUN.
- RUN: terminal state while healthy.
- Abort to HOLD (next edge; all three outputs go 0 on that edge):
  - pll_locked=0 in PERIPH, CALIB, CPU_GAP or RUN.
  - soft_rst_req=1 in any state except HOLD.
  - Priority: rst_i > lock loss > soft_rst_req > normal transition.
- calib_done falling after CALIB is ignored.
- Timing from E0, the first edge sampling rst_i=1, with lock and calib_done held high:
  - rst_periph_o rises at edge E(HOLD_CYCLES).
  - rst_mem_o rises at E(HOLD_CYCLES+STAGE_GAP).
  - rst_cpu_o rises at E(HOLD_CYCLES+2*STAGE_GAP+1).
  - Defaults: E16, E24, E33.
- Counter width: $clog2 of the largest parameter, plus 1.

Optional Feature:
- Macro: RESET_SEQ_RESTART_CNT_EN.
- Defined: restart_cnt_o increments once per abort or timeout transition into HOLD, saturating at 255. It is cleared only by rst_i=0.
- Undefined: no counter logic is built; restart_cnt_o is tied to 0.

Decomposition:
- Package reset_seq_pkg:
  - state encoding constants (HOLD through RUN) and a 3-bit state typedef.
  - restart counter width (8).
  - counter-width function.
- Natural sub-module: reset_seq_timer, a loadable/clearable up-counter with a terminal-count compare, reused for the hold, gap and timeout counts.

Test Plan:
- Defaults, lock=1, calib_done=1, release rst_i at E0 → periph high after E16, mem after E24, cpu after E33; state_o=5.
- Lock held 0 for 40 cycles after HOLD → state_o=1, all outputs 0; raise lock → periph rises the next edge.
- calib_done never asserts → after 4096 cycles in CALIB: state_o=0, mem/periph=0, calib_timeout_o=1, restart_cnt_o=1 (feature on). Sequence restarts.
- In RUN, drop pll_locked for 1 cycle → all outputs 0 next edge, state_o=0; full re-sequence follows; restart_cnt_o increments.
- soft_rst_req in CALIB in the same cycle as calib_done → HOLD is taken, not CPU_GAP.
- rst_i=0 for one edge in RUN → all outputs 0, calib_timeout_o=0, restart_cnt_o=0.
